wc_stream_driver: RTL and testbench

//   Host-side driver for the WC Winograd core: accepts input tiles on a valid/ready stream,

---
 rtl/wc_pkg.sv | 8 +
 rtl/wc_result_fifo.sv | 42 ++++
 rtl/wc_stream_driver.sv | 55 +++++
 tb/tb_wc_stream_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
// wc_pkg: WC core lane geometry shared by the core, the chip top and the stream driver.
package wc_pkg;
    localparam int LANES = 10;
    localparam int D_W = 7;
    localparam int Z_W = 3;
    localparam int D_BUS_W = LANES * D_W;
    localparam int Z_BUS_W = LANES * Z_W;
endpackage

// File: rtl/wc_result_fifo.sv
// wc_result_fifo: synchronous first-word-fall-through result FIFO with occupancy count.
module wc_result_fifo #(
    parameter int W = 30,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !do_pop));
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/wc_stream_driver.sv
// wc_stream_driver: credit-gated driver that issues tiles to the WC core and
// collects each tile's Z result, in acceptance order, into a result FIFO.
module wc_stream_driver
    import wc_pkg::*;
#(
    parameter int CORE_LAT = 3,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [D_BUS_W-1:0] s_data,
    output logic [D_BUS_W-1:0] core_D,
    input  logic [Z_BUS_W-1:0] core_Z,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Z_BUS_W-1:0] m_data,
    output logic               busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CORE_LAT-1:0] tag;
    logic [CW-1:0] inflight, fifo_count;
    logic [CW:0] credits_used;
    logic fire, capture, fifo_empty;
    // Every accepted tile holds a FIFO slot from issue until it is popped.
    assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign s_ready = !rst && credits_used < (CW + 1)'(DEPTH);
    assign fire = s_valid && s_ready;
    assign capture = tag[CORE_LAT-1];
    assign m_valid = !fifo_empty;
    assign busy = inflight != '0 || !fifo_empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_D <= '0;
            tag <= '0;
            inflight <= '0;
        end else begin
            core_D <= fire ? s_data : '0;
            tag <= CORE_LAT'({tag, fire});
            inflight <= inflight + CW'(fire) - CW'(capture);
        end
    end
    wc_result_fifo #(.W(Z_BUS_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(capture),
        .pop(m_ready),
        .wdata(core_Z),
        .rdata(m_data),
        .empty(fifo_empty),
        .full(),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_wc_stream_driver.sv
// tb_wc_stream_driver: directed bench with an outstanding-tile queue model and per-cycle compare.
module tb_wc_stream_driver;
    import wc_pkg::*;
    localparam int CORE_LAT = 3;
    localparam int DEPTH = 4;
    typedef struct {
        logic [Z_BUS_W-1:0] z;
        int t;
    } ent_t;
    logic clk = 0, rst = 1, s_valid = 0, m_ready = 0;
    logic s_ready, m_valid, busy;
    logic [D_BUS_W-1:0] s_data = '0, core_D;
    logic [Z_BUS_W-1:0] core_Z, m_data, p1;
    int vectors = 0, errors = 0, acc = 0, cyc = 0;
    logic [Z_BUS_W-1:0] got[$];
    ent_t q[$];
    logic [D_BUS_W-1:0] exp_d = '0;
    logic m_fire, m_pop, exp_v;
    always #5 clk = ~clk;
    wc_stream_driver #(.CORE_LAT(CORE_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_D(core_D), .core_Z(core_Z), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy)
    );
    function automatic logic [Z_BUS_W-1:0] zof(input logic [D_BUS_W-1:0] d);
        logic [Z_BUS_W-1:0] z = '0;
        for (int i = 0; i < LANES; i++) z[i*Z_W +: Z_W] = d[i*D_W +: Z_W];
        return z;
    endfunction
    function automatic logic [D_BUS_W-1:0] tile(input int k);
        logic [D_BUS_W-1:0] d = '0;
        for (int i = 0; i < LANES; i++) d[i*D_W +: D_W] = 7'((k * 5 + i * 11) & 127);
        return d;
    endfunction
    // Core stub: Z is sampleable CORE_LAT edges after core_D changes (core_D reg + two stages).
    always @(posedge clk) begin
        p1 <= zof(core_D);
        core_Z <= p1;
    end
    // Model: a tile occupies a credit from acceptance until its result is popped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_d = '0;
        end else begin
            m_pop = q.size() > 0 && q[0].t <= cyc && m_ready;
            m_fire = s_valid && q.size() < DEPTH;
            if (m_pop) void'(q.pop_front());
            if (m_fire) q.push_back('{zof(s_data), cyc + 1 + CORE_LAT});
            exp_d = m_fire ? s_data : '0;
            cyc++;
        end
    end
    always @(posedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) acc++;
            if (m_valid && m_ready) got.push_back(m_data);
        end
    end
    task automatic chk(input string n, input logic [D_BUS_W-1:0] act, input logic [D_BUS_W-1:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask
    always @(negedge clk) begin
        exp_v = !rst && q.size() > 0 && q[0].t <= cyc;
        chk("s_ready", D_BUS_W'(s_ready), D_BUS_W'(!rst && q.size() < DEPTH));
        chk("m_valid", D_BUS_W'(m_valid), D_BUS_W'(exp_v));
        chk("m_data", D_BUS_W'(m_data), D_BUS_W'(exp_v ? q[0].z : '0));
        chk("busy", D_BUS_W'(busy), D_BUS_W'(!rst && q.size() > 0));
        chk("core_D", core_D, rst ? '0 : exp_d);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic stream(input int n, input int base, input int budget);
        int start = acc;
        int c = 0;
        while (acc - start < n && c < budget) begin
            s_valid = 1;
            s_data = tile(base + acc - start);
            tick();
            c++;
        end
        s_valid = 0;
        s_data = '0;
        chk("stream_accepted", D_BUS_W'(acc - start), D_BUS_W'(n));
    endtask
    task automatic drain(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("drain_count", D_BUS_W'(got.size()), D_BUS_W'(n));
    endtask
    task automatic check_order(input int base, input int n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk("order", D_BUS_W'(got[i]), D_BUS_W'(zof(tile(base + i))));
    endtask
    initial begin
        int start;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // 1: single tile
        s_data = 70'h05;
        s_valid = 1;
        tick();
        s_valid = 0;
        s_data = '0;
        chk("t1_core_d", core_D, 70'h05);
        tick();
        tick();
        chk("t1_early", D_BUS_W'(m_valid), '0);
        tick();
        chk("t1_m_valid", D_BUS_W'(m_valid), 70'h1);
        chk("t1_m_data", D_BUS_W'(m_data), 70'h5);
        m_ready = 1;
        tick();
        m_ready = 0;
        chk("t1_busy", D_BUS_W'(busy), '0);
        chk("t1_count", D_BUS_W'(got.size()), 70'h1);
        // 2: backpressure
        got.delete();
        start = acc;
        stream(4, 1, 10);
        s_valid = 1;
        s_data = tile(5);
        repeat (5) tick();
        chk("t2_s_ready", D_BUS_W'(s_ready), '0);
        chk("t2_accepted", D_BUS_W'(acc - start), 70'h4);
        m_ready = 1;
        stream(2, 5, 20);
        drain(6, 20);
        check_order(1, 6);
        // 3: streaming
        got.delete();
        stream(20, 100, 60);
        drain(20, 20);
        check_order(100, 20);
        // 4: bubbles
        got.delete();
        for (int j = 0; j < 4; j++) begin
            s_valid = (j % 2) == 0;
            s_data = s_valid ? tile(200 + j / 2) : tile(999);
            tick();
            if (j % 2 == 1) chk("t4_bubble", core_D, '0);
        end
        s_valid = 0;
        s_data = '0;
        drain(2, 20);
        repeat (5) tick();
        chk("t4_count", D_BUS_W'(got.size()), 70'h2);
        check_order(200, 2);
        // 5: reset with two tiles in flight and one buffered
        m_ready = 0;
        got.delete();
        stream(1, 300, 10);
        tick();
        tick();
        stream(2, 301, 10);
        chk("t5_pre_busy", D_BUS_W'(busy), 70'h1);
        #1 rst = 1;
        #2;
        chk("t5_m_valid", D_BUS_W'(m_valid), '0);
        chk("t5_busy", D_BUS_W'(busy), '0);
        chk("t5_core_d", core_D, '0);
        #2 rst = 0;
        m_ready = 1;
        repeat (10) tick();
        chk("t5_no_results", D_BUS_W'(got.size()), '0);
        // 6: capture and pop on the same edge with all credits used
        m_ready = 0;
        stream(4, 400, 10);
        m_ready = 1;
        stream(2, 404, 20);
        drain(6, 20);
        check_order(400, 6);
        repeat (3) tick();
        chk("t6_idle", D_BUS_W'(busy), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
